counter_cmd_driver: RTL and testbench
=====================================

Name: counter_cmd_driver

Overview:
- Command-side initiator for an up/down loadable counter with `load`/`en`/`ud`/`cin` control and `cn` count output.
- Accepts one command at a time over a valid/ready handshake. Each command is: load a start value, then step N times in one direction.
- Drives the counter's control inputs cycle by cycle.
- Reads back `cn`, compares it against an internally tracked expected count, and flags mismatches.
- Sits between the test/control logic and the counter instance.

Parameters:
- WIDTH, 4, counter data width. Applies to `cin`, `cn`, expected count and step count.
- ERRW, 8, width of the saturating mismatch counter.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-low. rst=0 resets on the next rising edge.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_val  input  WIDTH  start value to load.
- cmd_dir  input  1  1=count up, 0=count down.
- cmd_steps  input  WIDTH  number of enable cycles after load (0..2^WIDTH-1).
- load  output  1  to counter `load`.
- en  output  1  to counter `en`.
- ud  output  1  to counter `ud`.
- cin  output  WIDTH  to counter `cin`.
- cn  input  WIDTH  counter output, read back.
- exp_cn  output  WIDTH  expected counter value.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a command completes.
- err  output  1  sticky mismatch flag; cleared only by reset.
- err_cnt  output  ERRW  number of mismatches, saturating at all-ones.

Behaviour:
- Reset (rst=0 at an edge):
  - state=IDLE.
  - load=en=ud=0, cin=0, exp_cn=0, done=0, err=0, err_cnt=0.
  - All internal step/check registers are cleared.
  - Reset mid-command aborts immediately: en/load are 0 from the first cycle after the reset edge, and no done is issued.
- All counter-side outputs (load, en, ud, cin) are registered.
- States and transitions:
  - IDLE: cmd_ready=1. On accept, capture cmd_val/cmd_dir/cmd_steps, then go to LOAD.
  - LOAD (1 cycle): load=1, en=1, cin=captured value, ud=cmd_dir. At the end of the cycle exp_cn <= value. Next state is STEP if steps>0, else WAIT.
  - STEP (exactly `steps` cycles): load=0, en=1, ud=dir, cin holds its value. Each cycle, exp_cn <= exp_cn±1 modulo 2^WIDTH and remaining decrements. When remaining=1 this cycle, next state is WAIT.
  - WAIT (1 cycle): en=0, load=0. done=1 in this cycle. Next state is IDLE.
- Timing, with the accept edge defined as cycle 0:
  - LOAD is cycle 1.
  - STEP is cycles 2..N+1.
  - WAIT/done is cycle N+2.
  - cmd_ready is high again in cycle N+3.
- Wrap-around arithmetic: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1. No saturation.
- Read-back check:
  - A chk register is set in each cycle following a cycle in which load=1 or en=1.
  - In a chk cycle, cn is compared with exp_cn. This covers the counter's one-cycle latency.
  - On mismatch: err<=1 and err_cnt increments (saturates).
  - The final check falls in the WAIT cycle; no check is made in IDLE.
- Simultaneous events:
  - cmd_valid asserted while busy is ignored (not queued); the requester must hold cmd_valid.
  - cmd_valid in the WAIT cycle is not accepted; it is accepted in the following IDLE cycle at the earliest.
- Command fields are sampled only at accept; later changes to cmd_* are ignored.
- err persists across commands.

Test Plan:
- Basic up: accept {val=0, dir=1, steps=5} with a correct counter.
  - Expect load=1 in cycle 1, en=1 in cycles 1..6, done in cycle 7.
  - Expect exp_cn=5 and cn=5 at done, err=0.
- Up wrap: {val=15, dir=1, steps=2} → exp_cn sequence 15, 0, 1; done with exp_cn=1; err=0.
- Down wrap: {val=1, dir=0, steps=3} → exp_cn sequence 1, 0, 15, 14; ud=0 throughout; done with exp_cn=14.
- Zero steps: {val=9, steps=0} → a single load pulse with cin=9, then done in cycle 2, exp_cn=9; cmd_ready high again in cycle 3.
- Mismatch: force cn stuck at 0 on {val=3, dir=1, steps=2} → 3 checked cycles all mismatch; err=1, err_cnt=3. err stays 1 through a following clean command.
- Reset and backpressure:
  - cmd_valid held during busy → no second accept until IDLE.
  - rst=0 in STEP cycle 3 of {steps=10} → load=en=0, busy=0, err_cnt=0, no done; the next command is accepted normally after rst=1.

Source files
------------

// File: rtl/counter_cmd_driver.sv
// Command driver for an up/down loadable counter: load, step N times,
// read back cn against a tracked expected count and flag mismatches.
//
// Ports:
//   clk, rst (sync, active-low)
//   cmd_valid/cmd_ready, cmd_val, cmd_dir, cmd_steps : command handshake
//   load, en, ud, cin : registered counter controls
//   cn                : counter read-back
//   exp_cn, busy, done, err, err_cnt : status
module counter_cmd_driver #(
  parameter int WIDTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_val,
  input  logic             cmd_dir,
  input  logic [WIDTH-1:0] cmd_steps,
  output logic             load,
  output logic             en,
  output logic             ud,
  output logic [WIDTH-1:0] cin,
  input  logic [WIDTH-1:0] cn,
  output logic [WIDTH-1:0] exp_cn,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERRW-1:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STEP,
    WAIT
  } state_t;

  state_t           state;
  state_t           nstate;
  logic [WIDTH-1:0] rem;
  logic             chk;
  logic             accept;

  assign accept = cmd_valid && (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (cmd_valid) nstate = LOAD;
      LOAD: nstate = (rem != '0) ? STEP : WAIT;
      STEP: if (rem == WIDTH'(1)) nstate = WAIT;
      WAIT: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    done      = (state == WAIT);
  end

  // Controls are registered from the next state so they line up
  // with the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst) begin
      load    <= 1'b0;
      en      <= 1'b0;
      ud      <= 1'b0;
      cin     <= '0;
      rem     <= '0;
      exp_cn  <= '0;
      chk     <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      load <= (nstate == LOAD);
      en   <= (nstate == LOAD) || (nstate == STEP);
      // Counter updates on the edge after load/en, so the
      // read-back is valid one cycle later.
      chk  <= load | en;
      if (accept) begin
        cin <= cmd_val;
        ud  <= cmd_dir;
        rem <= cmd_steps;
      end
      if (state == LOAD) begin
        exp_cn <= cin;
      end else if (state == STEP) begin
        exp_cn <= ud ? exp_cn + 1'b1 : exp_cn - 1'b1;
        rem    <= rem - 1'b1;
      end
      if (chk && (cn != exp_cn)) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_counter_cmd_driver.sv
// Bench for counter_cmd_driver: behavioural counter, directed commands,
// scoreboard queue checked by a monitor on the falling edge.
module tb_counter_cmd_driver;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_val;
  logic       cmd_dir;
  logic [3:0] cmd_steps;
  logic       load;
  logic       en;
  logic       ud;
  logic [3:0] cin;
  logic [3:0] cn;
  logic [3:0] exp_cn;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] err_cnt;

  counter_cmd_driver #(.WIDTH(4), .ERRW(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_val   (cmd_val),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .load      (load),
    .en        (en),
    .ud        (ud),
    .cin       (cin),
    .cn        (cn),
    .exp_cn    (exp_cn),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // counter under control
  logic [3:0] cnt;
  logic       stuck;
  always @(posedge clk) begin
    if (!rst)      cnt <= 4'd0;
    else if (load) cnt <= cin;
    else if (en)   cnt <= ud ? cnt + 4'd1 : cnt - 4'd1;
  end
  assign cn = stuck ? 4'd0 : cnt;

  typedef struct {
    logic [3:0] val;
    logic       dir;
    logic [3:0] steps;
    logic       err;
    logic [7:0] ecnt;
    int         acc;
  } cmd_t;

  cmd_t q[$];
  int   nvec  = 0;
  int   nfail = 0;

  task automatic check(string nm, logic [31:0] act,
                       logic [31:0] want);
    nvec++;
    if (act !== want) begin
      nfail++;
      $display("FAIL %s: got %0d want %0d cyc %0d",
               nm, act, want, cyc);
    end
  endtask

  // monitor
  int         last_done = -10;
  logic       p_err;
  logic [7:0] p_cnt;
  cmd_t       h;
  int         lo;
  int         hi;
  logic [3:0] e;

  always @(negedge clk) begin
    if (rst) begin
      if (q.size() > 0) begin
        h  = q[0];
        lo = h.acc + 1;
        hi = h.acc + int'(h.steps) + 1;
        if (cyc > h.acc && cyc <= hi) begin
          check("load", load, cyc == lo);
          check("en", en, 1);
          check("ud", ud, h.dir);
          check("cin", cin, h.val);
          check("done_early", done, 0);
          if (cyc > lo) begin
            e = h.dir ? h.val + 4'(cyc - lo - 1)
                      : h.val - 4'(cyc - lo - 1);
            check("exp_cn_step", exp_cn, e);
          end
        end
      end
      if (done) begin
        if (q.size() == 0) begin
          check("done_unexpected", done, 0);
        end else begin
          h = q.pop_front();
          e = h.dir ? h.val + h.steps : h.val - h.steps;
          check("done_cyc", cyc, h.acc + int'(h.steps) + 2);
          check("wait_load", load, 0);
          check("wait_en", en, 0);
          check("done_exp_cn", exp_cn, e);
          if (!stuck) check("done_cn", cn, e);
          p_err     = h.err;
          p_cnt     = h.ecnt;
          last_done = cyc;
        end
      end else if (cyc == last_done + 1) begin
        check("ready_after", cmd_ready, 1);
        check("busy_after", busy, 0);
        check("err", err, p_err);
        check("err_cnt", err_cnt, p_cnt);
      end
    end
  end

  task automatic issue(input logic [3:0] v, input logic d,
                       input logic [3:0] s, input logic xe,
                       input logic [7:0] xc, output int acc);
    cmd_t c;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_val   = v;
    cmd_dir   = d;
    cmd_steps = s;
    for (int t = 0; t < 60; t++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    if (!cmd_ready) check("accept_timeout", cmd_ready, 1);
    acc     = cyc;
    c.val   = v;
    c.dir   = d;
    c.steps = s;
    c.err   = xe;
    c.ecnt  = xc;
    c.acc   = acc;
    q.push_back(c);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_val   = ~v;
    cmd_dir   = ~d;
    cmd_steps = ~s;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 60; t++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      check("idle_timeout", q.size(), 0);
      q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_state(string tag);
    check({tag, "_load"}, load, 0);
    check({tag, "_en"}, en, 0);
    check({tag, "_ud"}, ud, 0);
    check({tag, "_cin"}, cin, 0);
    check({tag, "_exp_cn"}, exp_cn, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, cmd_ready, 1);
    check({tag, "_err"}, err, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
  endtask

  int a1;
  int a2;

  initial begin
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_val   = 4'd0;
    cmd_dir   = 1'b0;
    cmd_steps = 4'd0;
    stuck     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    rst = 1'b1;

    // basic up, wraps, zero steps
    issue(4'd0, 1'b1, 4'd5, 1'b0, 8'd0, a1);
    wait_idle();
    issue(4'd15, 1'b1, 4'd2, 1'b0, 8'd0, a1);
    wait_idle();
    issue(4'd1, 1'b0, 4'd3, 1'b0, 8'd0, a1);
    wait_idle();
    issue(4'd9, 1'b1, 4'd0, 1'b0, 8'd0, a1);
    wait_idle();

    // stuck counter: three checked cycles, all mismatch
    stuck = 1'b1;
    issue(4'd3, 1'b1, 4'd2, 1'b1, 8'd3, a1);
    wait_idle();
    stuck = 1'b0;
    issue(4'd7, 1'b0, 4'd1, 1'b1, 8'd3, a1);
    wait_idle();

    // second request held while busy
    issue(4'd4, 1'b1, 4'd3, 1'b1, 8'd3, a1);
    issue(4'd8, 1'b0, 4'd2, 1'b1, 8'd3, a2);
    check("accept_gap", a2 - a1, 6);
    wait_idle();

    // reset mid-STEP
    issue(4'd2, 1'b1, 4'd10, 1'b1, 8'd3, a1);
    for (int t = 0; t < 20; t++) begin
      if (cyc >= a1 + 4) break;
      @(negedge clk);
    end
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b1;
    repeat (4) @(negedge clk);
    issue(4'd6, 1'b1, 4'd3, 1'b0, 8'd0, a1);
    wait_idle();

    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

endmodule
